// File: rtl/hwt_seq_trigger.sv
// Sequential Trojan test article: decodes a strobed four-vector activation sequence on {A,B,C,D}
// and inverts the benign output Y for a bounded payload window.
module hwt_seq_trigger #(
    parameter logic [3:0] SEQ0           = 4'b1000,
    parameter logic [3:0] SEQ1           = 4'b1100,
    parameter logic [3:0] SEQ2           = 4'b1110,
    parameter logic [3:0] SEQ3           = 4'b1111,
    parameter int         GAP_MAX        = 16,
    parameter int         PAYLOAD_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    input  logic       stb,
    output logic       Y,
    output logic       trig,
    output logic [2:0] state,
    output logic [7:0] trig_cnt
);

    // state | meaning
    // IDLE  | waiting for SEQ0 strobe
    // S1    | SEQ0 seen, expecting SEQ1
    // S2    | SEQ1 seen, expecting SEQ2
    // S3    | SEQ2 seen, expecting SEQ3
    // ARMED | payload window active, Y inverted, strobes ignored
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S1    = 3'd1,
        S2    = 3'd2,
        S3    = 3'd3,
        ARMED = 3'd4
    } state_t;

    localparam logic [7:0] GAP_LAST = 8'(GAP_MAX - 1);
    localparam logic [7:0] PAY_LOAD = 8'(PAYLOAD_CYCLES - 1);

    state_t     state_q, state_d, nxt_state;
    logic [7:0] gap_q, gap_d;
    logic [7:0] pay_q, pay_d;
    logic [7:0] cnt_d;
    logic [3:0] vec, exp_vec;

    assign vec = {A, B, C, D};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gap_q    <= 8'd0;
            pay_q    <= 8'd0;
            trig_cnt <= 8'd0;
            trig     <= 1'b0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            pay_q    <= pay_d;
            trig_cnt <= cnt_d;
            trig     <= (state_d == ARMED);
        end
    end

    always_comb begin
        exp_vec   = SEQ1;
        nxt_state = S2;
        case (state_q)
            S2: begin
                exp_vec   = SEQ2;
                nxt_state = S3;
            end
            S3: begin
                exp_vec   = SEQ3;
                nxt_state = ARMED;
            end
            default: begin
                exp_vec   = SEQ1;
                nxt_state = S2;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        pay_d   = pay_q;
        cnt_d   = trig_cnt;
        case (state_q)
            IDLE: begin
                gap_d = 8'd0;
                if (stb && vec == SEQ0) state_d = S1;
            end
            S1, S2, S3: begin
                if (stb) begin
                    gap_d = 8'd0;
                    if (vec == exp_vec) begin
                        state_d = nxt_state;
                        if (nxt_state == ARMED) begin
                            pay_d = PAY_LOAD;
                            cnt_d = (trig_cnt == 8'hFF) ? trig_cnt : trig_cnt + 8'd1;
                        end
                    end else if (vec == SEQ0) begin
                        state_d = S1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                    gap_d   = 8'd0;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            ARMED: begin
                gap_d = 8'd0;
                if (pay_q == 8'd0) state_d = IDLE;
                else               pay_d   = pay_q - 8'd1;
            end
            default: begin
                state_d = IDLE;
                gap_d   = 8'd0;
                pay_d   = 8'd0;
            end
        endcase
    end

    // Decoded from the async-reset state so Y goes benign the moment rst_n falls.
    assign Y     = ((A & B) | (C & D)) ^ (state_q == ARMED);
    assign state = state_q;

endmodule

// File: tb/tb_hwt_seq_trigger.sv
// Directed bench for hwt_seq_trigger: default-parameter instance plus a PAYLOAD_CYCLES=1 instance
// used for trig_cnt saturation.
module tb_hwt_seq_trigger;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a, b, c, d, stb;
    logic       y, trig, y1, trig1;
    logic [2:0] state, state1;
    logic [7:0] trig_cnt, trig_cnt1;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    hwt_seq_trigger dut (
        .clk(clk), .rst_n(rst_n), .A(a), .B(b), .C(c), .D(d), .stb(stb),
        .Y(y), .trig(trig), .state(state), .trig_cnt(trig_cnt)
    );

    hwt_seq_trigger #(.PAYLOAD_CYCLES(1)) dut_p1 (
        .clk(clk), .rst_n(rst_n), .A(a), .B(b), .C(c), .D(d), .stb(stb),
        .Y(y1), .trig(trig1), .state(state1), .trig_cnt(trig_cnt1)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, return 1 time unit after the rising edge.
    task automatic cyc(input logic [3:0] v, input logic s);
        @(negedge clk);
        {a, b, c, d} = v;
        stb = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hi;
        rst_n = 1'b0;
        {a, b, c, d} = 4'b1100;
        stb = 1'b0;
        #22;
        chk("rst_y", y, 1);
        chk("rst_trig", trig, 0);
        chk("rst_state", state, 0);
        chk("rst_cnt", trig_cnt, 0);
        chk("rst_cnt_p1", trig_cnt1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full trigger
        cyc(4'h8, 1); chk("full_s1", state, 1);
        cyc(4'hC, 1); chk("full_s2", state, 2);
        cyc(4'hE, 1); chk("full_s3", state, 3);
        cyc(4'hF, 1);
        chk("full_armed", state, 4);
        chk("full_cnt", trig_cnt, 1);
        hi = 0;
        if (trig === 1'b1 && y === 1'b0) hi++;
        for (int i = 0; i < 20; i++) begin
            cyc(4'hF, 0);
            if (trig === 1'b1 && y === 1'b0) hi++;
        end
        chk("full_window_len", 8'(hi), 16);
        chk("full_after_y", y, 1);
        chk("full_after_trig", trig, 0);
        chk("full_after_state", state, 0);
        chk("full_after_cnt", trig_cnt, 1);

        // Gap timeout
        cyc(4'h8, 1);
        for (int i = 0; i < 15; i++) cyc(4'h0, 0);
        chk("gap15_hold", state, 1);
        cyc(4'hC, 1); chk("gap15_strobe", state, 2);
        cyc(4'h0, 1); chk("gap_back_idle", state, 0);
        cyc(4'h8, 1);
        for (int i = 0; i < 16; i++) cyc(4'h0, 0);
        chk("gap16_abort", state, 0);
        cyc(4'h8, 1);
        for (int i = 0; i < 15; i++) cyc(4'h0, 0);
        cyc(4'hC, 1); chk("gap16_strobe_wins", state, 2);
        cyc(4'h0, 1); chk("gap_idle2", state, 0);

        // Mismatch restart
        cyc(4'h8, 1); cyc(4'hC, 1); cyc(4'hB, 1);
        chk("mm_to_idle", state, 0);
        cyc(4'h8, 1); cyc(4'hC, 1); cyc(4'h8, 1);
        chk("mm_restart_s1", state, 1);
        cyc(4'hC, 1); cyc(4'hE, 1); cyc(4'hF, 1);
        chk("mm_trig", trig, 1);
        chk("mm_cnt", trig_cnt, 2);

        // Strobes of SEQ0 during ARMED are ignored until the window closes
        for (int i = 0; i < 15; i++) begin
            cyc(4'h8, 1);
            if (i == 0 || i == 14) chk("armed_ignore", state, 4);
        end
        cyc(4'h8, 1);
        chk("armed_end_state", state, 0);
        chk("armed_end_cnt", trig_cnt, 2);

        // Mid-payload reset
        cyc(4'h8, 1); cyc(4'hC, 1); cyc(4'hE, 1); cyc(4'hF, 1);
        chk("mpr_cnt", trig_cnt, 3);
        for (int i = 0; i < 4; i++) cyc(4'hF, 0);
        chk("mpr_y_inv", y, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mpr_trig", trig, 0);
        chk("mpr_y", y, 1);
        chk("mpr_state", state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4'h0, 0);
        chk("mpr_cnt_after", trig_cnt, 0);

        // Saturation on the single-cycle-payload instance
        for (int i = 0; i < 260; i++) begin
            cyc(4'h8, 1); cyc(4'hC, 1); cyc(4'hE, 1); cyc(4'hF, 1);
            if (i == 0) chk("p1_trig", trig1, 1);
            cyc(4'h0, 0);
            if (i == 0) chk("p1_window", trig1, 0);
            if (i == 199) chk("p1_cnt200", trig_cnt1, 200);
        end
        chk("p1_cnt_sat", trig_cnt1, 255);
        chk("p1_state", state1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hwt_seq_trigger.md
# hwt_seq_trigger

Sequential hardware-Trojan test article. It watches the same four single-bit inputs A, B, C, D that our combinational Trojan benches drive, and detects a strobed four-vector activation sequence. On detection it corrupts the functional output Y for a bounded payload window. It is the receiving end of the activation-pattern stimulus: the bench transmits the vector sequence and this block decodes it.

## Interface
Parameters:
- SEQ0, 4'b1000: first trigger vector, encoded {A,B,C,D}
- SEQ1, 4'b1100: second trigger vector
- SEQ2, 4'b1110: third trigger vector
- SEQ3, 4'b1111: fourth trigger vector
- GAP_MAX, 16: consecutive strobe-less cycles that abort a partial match (legal range 1..255)
- PAYLOAD_CYCLES, 16: length of the payload window in cycles (legal range 1..255)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- A, B, C, D  in  1 each  functional inputs
- stb  in  1  sample strobe; {A,B,C,D} is evaluated only on edges where stb=1
- Y  out  1  functional output, combinational: (A&B)|(C&D), inverted while the payload is active
- trig  out  1  registered; 1 while in ARMED
- state  out  3  registered FSM state (debug)
- trig_cnt  out  8  registered count of completed triggers; saturates at 255

## Operation
- Vector v = {A,B,C,D}.
- State encoding: IDLE=0, S1=1, S2=2, S3=3, ARMED=4.
- IDLE:
  - stb & v==SEQ0 → S1.
  - Any other strobe → stay in IDLE.
- S1, S2, S3:
  - stb & v==expected (SEQ1, SEQ2 or SEQ3 respectively) → next state (S2, S3 or ARMED).
  - stb & mismatch & v==SEQ0 → S1.
  - stb & mismatch & v!=SEQ0 → IDLE.
  - No lookahead beyond this restart rule.
- Gap counter (8-bit):
  - Cleared on every accepted strobe and on every state change.
  - Increments on each cycle in S1–S3 with stb=0.
  - In S1–S3, stb=0 & gap==GAP_MAX-1 → IDLE, gap cleared. The GAP_MAX-th consecutive idle cycle therefore aborts.
  - A strobe on that same cycle takes priority over the abort.
- S3 → ARMED transition:
  - trig_cnt increments (saturating at 255).
  - Payload counter loads PAYLOAD_CYCLES-1.
- ARMED:
  - Strobes are ignored.
  - Payload counter decrements each cycle.
  - At count 0, next state is IDLE.
- Y = ((A&B)|(C&D)) ^ (state==ARMED). Y stays combinational from the inputs in all states.
- Reset (rst_n low, at any time including mid-sequence or mid-payload):
  - state=IDLE, trig=0, trig_cnt=0, gap=0, payload counter=0.
  - Y reverts to the benign function immediately, without waiting for a clock edge.

## Timing
- All state updates occur on the rising clk edge. The strobe, vector and transition are evaluated at the same edge.
- Trigger latency: if the SEQ3 strobe is sampled at edge k, then trig=1 and Y is inverted from edge k until edge k+PAYLOAD_CYCLES, when the state returns to IDLE. trig is high for exactly PAYLOAD_CYCLES cycles.
- The earliest a new sequence can be accepted is the edge k+PAYLOAD_CYCLES+1 (an SEQ0 strobe in IDLE).
- trig_cnt reflects the new count from edge k.
- Back-to-back strobes on consecutive edges are legal. The minimum trigger spacing is 4 strobes plus the payload window.
- Reset deassertion must be synchronous to clk at the integration level. The block does not synchronize rst_n itself.

## Test plan
- Reset: hold rst_n=0 with A=B=1, C=D=0 → Y=1, trig=0, state=0, trig_cnt=0.
- Full trigger: strobe 8, C, E, F on 4 consecutive edges, then apply A=B=C=D=1 → Y=0 and trig=1 for exactly 16 cycles, then Y=1, trig=0, state=0, trig_cnt=1.
- Mismatch restart:
  - Strobe 8, C, B → state=0.
  - Then strobe 8, C, 8 → state=1.
  - Then strobe C, E, F → trig=1.
- Gap timeout:
  - Strobe 8, hold stb=0 for 15 cycles, strobe C → state=2.
  - Strobe 8, hold stb=0 for 16 cycles → state=0.
  - Strobe on the 16th idle cycle with v=C → state=2 (strobe wins over abort).
- Mid-payload reset: trigger, assert rst_n=0 at payload cycle 5 → trig=0 and Y benign before the next edge; trig_cnt=0 after release.
- Saturation/ignored strobes:
  - With PAYLOAD_CYCLES=1, run 260 triggers → trig_cnt=255.
  - Strobes of 8 during ARMED leave state=4 until the window ends.
